// File: rtl/rs232_xcvr.sv
// Full-duplex RS232 transceiver: valid/ready TX serialiser and a mid-bit sampling RX
// deserialiser with parity and framing error flags. TX and RX share only the clock and reset.
module rs232_xcvr #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 868,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              _clk,
  input  logic              _rst,
  input  logic              _rx,
  output logic              _tx,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_perr,
  output logic              rx_ferr
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // Odd parity makes the total count of ones (data + parity) odd, even makes it even.
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [2:0]        tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [IDX_W-1:0]  tx_idx;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par;

  assign tx_ready = (tx_state == TX_IDLE);

  always_ff @(posedge _clk) begin
    if (_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      _tx      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= tx_data;
            tx_par   <= parity_of(tx_data);
            _tx      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
            _tx      <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == DATA_LAST) begin
              tx_idx <= '0;
              if (HAS_PAR) begin
                tx_state <= TX_PARITY;
                _tx      <= tx_par;
              end else begin
                tx_state <= TX_STOP;
                _tx      <= 1'b1;
              end
            end else begin
              tx_idx   <= tx_idx + IDX_ONE;
              tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
              _tx      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_STOP;
            _tx      <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          // tx_idx counts stop bits here; the line simply stays high throughout.
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == STOP_LAST) begin
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + IDX_ONE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          _tx      <= 1'b1;
        end
      endcase
    end
  end

  logic              rx_meta;
  logic              rx_sync;
  logic [2:0]        rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [IDX_W-1:0]  rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_par_bit;

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge _clk) begin
    if (_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= _rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge _clk) begin
    if (_rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is gone by mid-bit is noise, not a frame.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
            if (rx_idx == DATA_LAST) begin
              rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_ONE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt     <= '0;
            rx_par_bit <= rx_sync;
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
            rx_perr  <= HAS_PAR & (rx_par_bit ^ parity_of(rx_shift));
            rx_ferr  <= ~rx_sync;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_xcvr.sv
// Randomised self-checking bench for rs232_xcvr (8 data bits, 16 clocks/bit, even parity, 1 stop).
// Expected serial frames and received words come from a frame-level model of the line protocol.
module tb_rs232_xcvr;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 16;
  localparam int NBITS   = 11;
  localparam int FRAME   = NBITS * CLK_DIV;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_line;
  logic       rx_line;
  logic       drv_rx = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perr;
  logic       rx_ferr;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  logic prev_v = 1'b0;
  rx_rec_t rxq[$];

  assign rx_line = loop_en ? tx_line : drv_rx;

  rs232_xcvr #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .PARITY(2), .STOP_BITS(1)
  ) dut (
    ._clk(clk), ._rst(rst), ._rx(rx_line), ._tx(tx_line),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr), .rx_ferr(rx_ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Collects every received word; a pulse longer than one cycle is itself an error.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rxq.push_back({rx_ferr, rx_perr, rx_data});
      total++;
      if (prev_v) begin
        bad++;
        $display("[TB] FAIL rx_valid_single_cycle: observed 1 on two consecutive cycles, required single pulse");
      end
    end
    prev_v <= rx_valid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line-level frame: start 0, data LSB first, even parity, stop 1; unused upper bits idle high.
  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    f[9] = ^d;
    return f;
  endfunction

  task automatic drive_rx_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv_rx = bits[i];
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rxq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic send_word(input logic [7:0] d, output int acc);
    int n;
    acc = -1;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready) begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc_cnt;
    end
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("[TB] FAIL %s_tx: got %b want 1", tag, tx_line); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_tx_ready: got %b want 1", tag, tx_ready); end
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_rx_valid: got %b want 0", tag, rx_valid); end
    total++;
    if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL %s_rx_data: got %h want 00", tag, rx_data); end
    total++;
    if (rx_perr !== 1'b0) begin bad++; $display("[TB] FAIL %s_rx_perr: got %b want 0", tag, rx_perr); end
    total++;
    if (rx_ferr !== 1'b0) begin bad++; $display("[TB] FAIL %s_rx_ferr: got %b want 0", tag, rx_ferr); end
  endtask

  task automatic check_rx_word(input string tag, input logic [7:0] d, input logic perr, input logic ferr);
    rx_rec_t r;
    total++;
    if (rxq.size() != 1) begin
      bad++;
      $display("[TB] FAIL %s_count: got %0d words want 1", tag, rxq.size());
    end else begin
      r = rxq.pop_front();
      total++;
      if (r.data !== d) begin bad++; $display("[TB] FAIL %s_data: got %h want %h", tag, r.data, d); end
      total++;
      if (r.perr !== perr) begin bad++; $display("[TB] FAIL %s_perr: got %b want %b", tag, r.perr, perr); end
      total++;
      if (r.ferr !== ferr) begin bad++; $display("[TB] FAIL %s_ferr: got %b want %b", tag, r.ferr, ferr); end
    end
    rxq.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int acc;
    check_idle_outputs("por");
    d = 8'($urandom_range(1, 255));
    rxq.delete();
    drive_rx_bits(frame_bits(d), NBITS);
    drv_rx = 1'b1;
    wait_rx(1, 3 * CLK_DIV);
    check_rx_word("pre_reset_rx", d, 1'b0, 1'b0);
    send_word(8'h00, acc);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("[TB] FAIL reset_abort_tx: got %b want 1", tx_line); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_tx_frame(input logic [7:0] d);
    logic [15:0] fb;
    logic bad_tx, bad_rdy, obs_tx, obs_rdy;
    fb = frame_bits(d);
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_ready_before: got %b want 1", tx_ready); end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = ~d;
    for (int b = 0; b < NBITS; b++) begin
      bad_tx = 1'b0;
      bad_rdy = 1'b0;
      obs_tx = fb[b];
      obs_rdy = 1'b0;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (tx_line !== fb[b]) begin bad_tx = 1'b1; obs_tx = tx_line; end
        if (tx_ready !== 1'b0) begin bad_rdy = 1'b1; obs_rdy = tx_ready; end
        if (b == NBITS - 1 && c == CLK_DIV - 1) tx_valid = 1'b0;
        @(negedge clk);
      end
      total++;
      if (bad_tx) begin bad++; $display("[TB] FAIL tx_bit%0d word %h: got %b want %b", b, d, obs_tx, fb[b]); end
      total++;
      if (bad_rdy) begin bad++; $display("[TB] FAIL tx_busy_bit%0d: tx_ready got %b want 0", b, obs_rdy); end
    end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL tx_ready_after: got %b want 1", tx_ready); end
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("[TB] FAIL tx_idle_after: got %b want 1", tx_line); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[5];
    int acc[5];
    rx_rec_t r;
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    for (int i = 2; i < 5; i++) words[i] = 8'($urandom);
    loop_en = 1'b1;
    rxq.delete();
    for (int i = 0; i < 5; i++) send_word(words[i], acc[i]);
    wait_rx(5, 2 * FRAME);
    repeat (2 * CLK_DIV) @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      total++;
      if (acc[i - 1] < 0 || acc[i] < 0 || acc[i] - acc[i - 1] != FRAME + 1) begin
        bad++;
        $display("[TB] FAIL b2b_spacing%0d: got %0d cycles want %0d", i, acc[i] - acc[i - 1], FRAME + 1);
      end
    end
    total++;
    if (rxq.size() != 5) begin
      bad++;
      $display("[TB] FAIL loopback_count: got %0d words want 5", rxq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        r = rxq[i];
        total++;
        if (r !== {1'b0, 1'b0, words[i]}) begin
          bad++;
          $display("[TB] FAIL loopback_word%0d: got data=%h perr=%b ferr=%b want data=%h perr=0 ferr=0",
                   i, r.data, r.perr, r.ferr, words[i]);
        end
      end
    end
    rxq.delete();
    loop_en = 1'b0;
  endtask

  task automatic test_parity_error();
    logic [15:0] fb;
    logic [7:0] d;
    logic flip;
    rxq.delete();
    fb = frame_bits(8'h01);
    fb[9] = 1'b0;
    drive_rx_bits(fb, NBITS);
    wait_rx(1, 3 * CLK_DIV);
    check_rx_word("perr_01", 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      flip = 1'(i % 2);
      fb = frame_bits(d);
      fb[9] = fb[9] ^ flip;
      drive_rx_bits(fb, NBITS);
      wait_rx(1, 3 * CLK_DIV);
      check_rx_word("perr_rand", d, flip, 1'b0);
    end
  endtask

  task automatic test_framing_error();
    logic [15:0] fb;
    rxq.delete();
    fb = frame_bits(8'h55);
    drive_rx_bits(fb, NBITS - 1);
    drv_rx = 1'b0;
    repeat (CLK_DIV + 200) @(negedge clk);
    check_rx_word("ferr_55", 8'h55, 1'b0, 1'b1);
    drv_rx = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
    drive_rx_bits(frame_bits(8'h12), NBITS);
    wait_rx(1, 3 * CLK_DIV);
    check_rx_word("after_break", 8'h12, 1'b0, 1'b0);
  endtask

  task automatic test_glitch_and_abort();
    logic [7:0] d;
    int acc;
    rxq.delete();
    drv_rx = 1'b0;
    repeat (4) @(negedge clk);
    drv_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    total++;
    if (rxq.size() != 0) begin bad++; $display("[TB] FAIL glitch_rx_valid: got %0d words want 0", rxq.size()); end
    d = 8'($urandom);
    drive_rx_bits(frame_bits(d), NBITS);
    wait_rx(1, 3 * CLK_DIV);
    check_rx_word("post_glitch", d, 1'b0, 1'b0);
    d = 8'($urandom) & 8'hF7;
    send_word(d, acc);
    repeat (70) @(negedge clk);
    total++;
    if (tx_line !== 1'b0) begin bad++; $display("[TB] FAIL tx_data_bit3: got %b want 0", tx_line); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx: got %b want 1", tx_line); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx_ready: got %b want 1", tx_ready); end
    rst = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx_stays_idle: got %b want 1", tx_line); end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_tx_frame(8'hA5);
    test_tx_frame(8'($urandom));
    test_tx_frame(8'($urandom));
    test_back_to_back();
    test_parity_error();
    test_framing_error();
    test_glitch_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
